// File: rtl/tlu_trigger_emulator_if.sv
// RJ45 link between the TLU emulator (master) and the TLU controller (slave).
interface tlu_trigger_emulator_if;
  logic TLU_TRIGGER;
  logic TLU_RESET;
  logic TLU_BUSY;
  logic TLU_CLOCK;

  modport master (output TLU_TRIGGER, output TLU_RESET, input TLU_BUSY, input TLU_CLOCK);
  modport slave  (input TLU_TRIGGER, input TLU_RESET, output TLU_BUSY, output TLU_CLOCK);
endinterface

// File: rtl/tlu_trigger_emulator.sv
// EUDET TLU 0.1/0.2 emulator: periodic triggers, busy/clock handshake in three
// modes, serial trigger-number readout and TLU reset pulses.
module tlu_trigger_emulator #(
  parameter int TRIGGER_BITS = 15,
  parameter int PERIOD_WIDTH = 16
) (
  input  logic                    BUS_CLK,
  input  logic                    BUS_RST_N,
  input  logic                    ENABLE,
  input  logic [1:0]              MODE,
  input  logic [PERIOD_WIDTH-1:0] PERIOD,
  input  logic [3:0]              PULSE_LEN,
  input  logic                    RESET_CMD,
  input  logic                    ERROR_CLR,
  tlu_trigger_emulator_if.master  tlu,
  output logic [31:0]             TRIGGER_NUMBER,
  output logic                    ACTIVE,
  output logic                    TIMEOUT_ERROR
);

  localparam logic [4:0] IDX_MAX = 5'(TRIGGER_BITS);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_PERIOD, S_TRIG, S_SHIFT, S_WAIT_RELEASE, S_DONE, S_RST_PULSE
  } state_e;

  state_e                  state_q, state_d;
  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]              tcnt_q, tcnt_d;
  logic [4:0]              idx_q, idx_d;
  logic [1:0]              rcnt_q, rcnt_d;
  logic                    trig_q, trig_d;
  logic                    rst_q, rst_d;
  logic [31:0]             trig_num_q, trig_num_d;
  logic                    pend_q, pend_d;
  logic                    err_q, err_d;
  logic [1:0]              busy_sync_q;
  logic [2:0]              clk_sync_q;

  logic       busy_s, clk_rise, rst_req, handshake, data_mode, timeout, start_rst;
  logic [3:0] plen;

  assign busy_s    = busy_sync_q[1];
  assign clk_rise  = clk_sync_q[1] & ~clk_sync_q[2];
  assign rst_req   = pend_q | RESET_CMD;
  assign handshake = |MODE;
  assign data_mode = MODE[1];
  assign plen      = (PULSE_LEN == 4'd0) ? 4'd1 : PULSE_LEN;

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      busy_sync_q <= '0;
      clk_sync_q  <= '0;
    end else begin
      busy_sync_q <= {busy_sync_q[0], tlu.TLU_BUSY};
      clk_sync_q  <= {clk_sync_q[1:0], tlu.TLU_CLOCK};
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tcnt_d     = tcnt_q;
    idx_d      = idx_q;
    rcnt_d     = rcnt_q;
    trig_d     = trig_q;
    rst_d      = rst_q;
    trig_num_d = trig_num_q;
    pend_d     = pend_q;
    err_d      = err_q;
    timeout    = 1'b0;
    start_rst  = 1'b0;
    if (ERROR_CLR) err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rst_req)     start_rst = 1'b1;
        else if (ENABLE) begin
          cnt_d   = PERIOD;
          state_d = S_WAIT_PERIOD;
        end
      end
      S_WAIT_PERIOD: begin
        if (rst_req)              start_rst = 1'b1;
        else if (!ENABLE)         state_d = S_IDLE;
        else if (cnt_q == '0) begin
          trig_d  = 1'b1;
          tcnt_d  = '0;
          state_d = S_TRIG;
        end else                  cnt_d = cnt_q - 1'b1;
      end
      S_TRIG: begin
        pend_d = rst_req;
        if (!handshake) begin
          if (tcnt_q >= {4'd0, plen} - 8'd1) begin
            trig_d  = 1'b0;
            state_d = S_DONE;
          end else tcnt_d = tcnt_q + 8'd1;
        end else if (busy_s) begin
          trig_d  = 1'b0;
          idx_d   = '0;
          state_d = data_mode ? S_SHIFT : S_WAIT_RELEASE;
        end else if (tcnt_q == 8'hFF) begin
          // 256th cycle without busy: give up on this trigger
          timeout = 1'b1;
          trig_d  = 1'b0;
          state_d = S_DONE;
        end else tcnt_d = tcnt_q + 8'd1;
      end
      S_SHIFT: begin
        pend_d = rst_req;
        if (!busy_s) begin
          trig_d  = 1'b0;
          idx_d   = '0;
          state_d = S_DONE;
        end else if (clk_rise) begin
          if (idx_q < IDX_MAX) begin
            trig_d = trig_num_q[idx_q];
            idx_d  = idx_q + 5'd1;
          end else trig_d = 1'b0;
        end
      end
      S_WAIT_RELEASE: begin
        pend_d = rst_req;
        if (!busy_s) state_d = S_DONE;
      end
      S_DONE: begin
        pend_d     = rst_req;
        trig_num_d = trig_num_q + 32'd1;
        cnt_d      = PERIOD;
        state_d    = (ENABLE && !rst_req) ? S_WAIT_PERIOD : S_IDLE;
      end
      S_RST_PULSE: begin
        if (rcnt_q == 2'd3) begin
          rst_d   = 1'b0;
          pend_d  = 1'b0;
          state_d = S_IDLE;
        end else rcnt_d = rcnt_q + 2'd1;
      end
      default: state_d = S_IDLE;
    endcase

    if (start_rst) begin
      rst_d      = 1'b1;
      rcnt_d     = '0;
      trig_num_d = '0;
      state_d    = S_RST_PULSE;
    end
    if (timeout) err_d = 1'b1;
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      tcnt_q     <= '0;
      idx_q      <= '0;
      rcnt_q     <= '0;
      trig_q     <= 1'b0;
      rst_q      <= 1'b0;
      trig_num_q <= '0;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tcnt_q     <= tcnt_d;
      idx_q      <= idx_d;
      rcnt_q     <= rcnt_d;
      trig_q     <= trig_d;
      rst_q      <= rst_d;
      trig_num_q <= trig_num_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
    end
  end

  assign tlu.TLU_TRIGGER = trig_q;
  assign tlu.TLU_RESET   = rst_q;
  assign TRIGGER_NUMBER  = trig_num_q;
  assign ACTIVE          = (state_q != S_IDLE);
  assign TIMEOUT_ERROR   = err_q;

endmodule

// File: tb/tb_tlu_trigger_emulator.sv
// Randomized bench for tlu_trigger_emulator with a transaction-level timing model.
module tb_tlu_trigger_emulator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] period = '0;
  logic [3:0]  plen = '0;
  logic        reset_cmd = 1'b0;
  logic        error_clr = 1'b0;
  logic [31:0] trig_num;
  logic        active, timeout_err;

  tlu_trigger_emulator_if tlu();

  tlu_trigger_emulator #(.TRIGGER_BITS(15), .PERIOD_WIDTH(16)) dut (
    .BUS_CLK(clk), .BUS_RST_N(rst_n), .ENABLE(enable), .MODE(mode), .PERIOD(period),
    .PULSE_LEN(plen), .RESET_CMD(reset_cmd), .ERROR_CLR(error_clr), .tlu(tlu.master),
    .TRIGGER_NUMBER(trig_num), .ACTIVE(active), .TIMEOUT_ERROR(timeout_err)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] exp_num = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ticks until TLU_TRIGGER equals val; -1 when the bound expires
  task automatic wait_trig(input logic val, input int max, output int n);
    n = 0;
    while (tlu.TLU_TRIGGER !== val && n < max) begin
      tick();
      n++;
    end
    if (tlu.TLU_TRIGGER !== val) n = -1;
  endtask

  task automatic count_reset(input int win, output int first, output int highs);
    first = -1; highs = 0;
    for (int i = 1; i <= win; i++) begin
      tick();
      if (tlu.TLU_RESET === 1'b1) begin
        highs++;
        if (first < 0) first = i;
      end
    end
  endtask

  task automatic run_mode0(input int p, input int l, input int ntx);
    int n, lexp;
    lexp = (l == 0) ? 1 : l;
    mode = 2'b00; period = 16'(p); plen = 4'(l); enable = 1'b1;
    wait_trig(1'b1, p + 10, n); check("m0_first_rise", n, p + 2);
    for (int i = 0; i < ntx; i++) begin
      check("m0_num", trig_num, exp_num);
      wait_trig(1'b0, 40, n); check("m0_high_len", n, lexp);
      exp_num++;
      if (i < ntx - 1) begin
        wait_trig(1'b1, p + 10, n); check("m0_low_len", n, p + 2);
      end
    end
    enable = 1'b0;
    tick(3);
    check("m0_num_end", trig_num, exp_num);
    check("m0_idle", active, 1'b0);
  endtask

  task automatic run_mode1(input int p, input int ntx);
    int n, d, h;
    mode = 2'b01; period = 16'(p); enable = 1'b1;
    wait_trig(1'b1, p + 10, n); check("m1_first_rise", n, p + 2);
    for (int i = 0; i < ntx; i++) begin
      check("m1_num", trig_num, exp_num);
      if (i == ntx - 1) enable = 1'b0;
      d = int'($urandom_range(1, 8)); tick(d);
      tlu.TLU_BUSY = 1'b1;
      wait_trig(1'b0, 20, n); check("m1_busy_to_fall", n, 3);
      h = int'($urandom_range(5, 25)); tick(h);
      tlu.TLU_BUSY = 1'b0;
      exp_num++;
      if (i < ntx - 1) begin
        wait_trig(1'b1, p + 20, n); check("m1_gap", n, p + 5);
      end
    end
    tick(6);
    check("m1_num_end", trig_num, exp_num);
    check("m1_idle", active, 1'b0);
  endtask

  // one data-handshake transaction driven by a DIVISOR 12 controller model
  task automatic data_tx(input int p, input bit rst_pulses);
    int n;
    logic [17:0] word;
    word = '0;
    mode = 2'($urandom_range(2, 3)); period = 16'(p); enable = 1'b1;
    wait_trig(1'b1, p + 10, n); check("m2_rise", n, p + 2);
    enable = 1'b0;
    tlu.TLU_BUSY = 1'b1;
    wait_trig(1'b0, 20, n); check("m2_busy_to_fall", n, 3);
    for (int b = 0; b < 18; b++) begin
      tlu.TLU_CLOCK = 1'b1;
      tick(6);
      word[b] = tlu.TLU_TRIGGER;
      tlu.TLU_CLOCK = 1'b0;
      if (rst_pulses && (b == 3 || b == 5)) begin
        reset_cmd = 1'b1; tick(1); reset_cmd = 1'b0; tick(5);
      end else tick(6);
    end
    check("m2_data", word[14:0], exp_num[14:0]);
    check("m2_tail_zero", word[17:15], 3'b000);
    tlu.TLU_BUSY = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, first, highs;
    tlu.TLU_BUSY = 1'b0;
    tlu.TLU_CLOCK = 1'b0;
    tick(3);
    check("rst_trigger", tlu.TLU_TRIGGER, 1'b0);
    check("rst_reset", tlu.TLU_RESET, 1'b0);
    check("rst_num", trig_num, 32'd0);
    check("rst_active", active, 1'b0);
    check("rst_err", timeout_err, 1'b0);
    rst_n = 1'b1;
    tick(2);

    run_mode0(10, 3, 5);
    repeat (3) run_mode0(int'($urandom_range(0, 20)), int'($urandom_range(0, 15)),
                         int'($urandom_range(1, 4)));

    // reset request from IDLE is served at once
    reset_cmd = 1'b1; tick(1); reset_cmd = 1'b0;
    check("idle_rst_high", tlu.TLU_RESET, 1'b1);
    count_reset(10, first, highs);
    check("idle_rst_len", highs, 3);
    exp_num = '0;
    check("idle_rst_num", trig_num, exp_num);

    run_mode1(10, 3);
    repeat (2) run_mode1(int'($urandom_range(0, 15)), int'($urandom_range(1, 3)));

    // data readout of a preset number
    force dut.trig_num_q = 32'h0000_5A3C;
    tick(1);
    release dut.trig_num_q;
    tick(1);
    exp_num = 32'h0000_5A3C;
    check("m2_preset", trig_num, exp_num);
    data_tx(int'($urandom_range(0, 10)), 1'b0);
    tick(6);
    exp_num++;
    check("m2_num_end", trig_num, exp_num);
    check("m2_idle", active, 1'b0);

    // busy never acknowledged
    mode = 2'b01; period = 16'd3; enable = 1'b1;
    wait_trig(1'b1, 20, n); check("to_rise", n, 5);
    enable = 1'b0;
    wait_trig(1'b0, 300, n); check("to_high_len", n, 256);
    check("to_err_set", timeout_err, 1'b1);
    tick(3);
    exp_num++;
    check("to_num", trig_num, exp_num);
    check("to_err_sticky", timeout_err, 1'b1);
    error_clr = 1'b1; tick(1); error_clr = 1'b0;
    check("to_err_clr", timeout_err, 1'b0);

    // reset requested during SHIFT is deferred until after DONE
    data_tx(5, 1'b1);
    count_reset(20, first, highs);
    check("dr_rst_delay", first, 5);
    check("dr_rst_len", highs, 4);
    exp_num = '0;
    check("dr_num", trig_num, exp_num);

    // wrap
    force dut.trig_num_q = 32'hFFFF_FFFF;
    tick(1);
    release dut.trig_num_q;
    tick(1);
    exp_num = 32'hFFFF_FFFF;
    run_mode0(2, 1, 1);
    check("wrap_zero", trig_num, 32'd0);
    run_mode0(int'($urandom_range(0, 5)), 2, 1);

    // async reset in the middle of SHIFT with a reset request pending
    mode = 2'b10; period = 16'd2; enable = 1'b1;
    wait_trig(1'b1, 20, n); check("ar_rise", n, 4);
    enable = 1'b0;
    tlu.TLU_BUSY = 1'b1;
    wait_trig(1'b0, 20, n); check("ar_fall", n, 3);
    tlu.TLU_CLOCK = 1'b1; tick(4);
    check("ar_bit0", tlu.TLU_TRIGGER, exp_num[0]);
    reset_cmd = 1'b1; tick(1); reset_cmd = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("ar_trigger", tlu.TLU_TRIGGER, 1'b0);
    check("ar_reset", tlu.TLU_RESET, 1'b0);
    check("ar_num", trig_num, 32'd0);
    check("ar_active", active, 1'b0);
    check("ar_err", timeout_err, 1'b0);
    tlu.TLU_BUSY = 1'b0; tlu.TLU_CLOCK = 1'b0;
    tick(2);
    rst_n = 1'b1;
    exp_num = '0;
    count_reset(10, first, highs);
    check("ar_no_pending", highs, 0);
    check("ar_idle", active, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/tlu_trigger_emulator.md
# tlu_trigger_emulator

Emulates a EUDET TLU 0.1/0.2 so that the TLU controller can be exercised on the bench without real telescope hardware. It generates triggers at a programmable interval and services the controller's busy/clock handshake in three modes (no handshake, simple handshake, trigger data handshake). It shifts the current trigger number out serially and issues TLU reset pulses. It sits directly upstream of the TLU controller: its `TLU_TRIGGER` and `TLU_RESET` outputs drive the controller's RJ45 inputs, and the controller's `TLU_BUSY` and `TLU_CLOCK` outputs feed back into it.

## Interface

Parameters:
- `TRIGGER_BITS`, default 15: number of trigger number bits shifted out in data handshake mode (valid range 1–31).
- `PERIOD_WIDTH`, default 16: width of `PERIOD`.

Ports:
- `BUS_CLK` in 1: single clock for all logic.
- `BUS_RST_N` in 1: asynchronous, active-low reset.
- `ENABLE` in 1: level; allows new triggers to start.
- `MODE` in 2: handshake mode; 00 = no handshake, 01 = simple handshake, 10 = data handshake, 11 = treated as 10.
- `PERIOD` in PERIOD_WIDTH: idle cycles between the end of one transaction and the next trigger assertion.
- `PULSE_LEN` in 4: trigger high time in mode 00, in cycles; value 0 is treated as 1.
- `RESET_CMD` in 1: single-cycle request to clear the trigger number and pulse `TLU_RESET`.
- `ERROR_CLR` in 1: single-cycle; clears `TIMEOUT_ERROR`.
- `TLU_BUSY` in 1: from the controller; asynchronous, synchronized internally.
- `TLU_CLOCK` in 1: from the controller; asynchronous, synchronized internally.
- `TLU_TRIGGER` out 1: trigger line, and serial data line in data mode. Registered.
- `TLU_RESET` out 1: reset line. Registered.
- `TRIGGER_NUMBER` out 32: number of completed transactions; this is the value shifted out in the next transaction.
- `ACTIVE` out 1: high in every state except IDLE.
- `TIMEOUT_ERROR` out 1: sticky; set when busy is not acknowledged.

## Operation

Reset values: all outputs 0; state IDLE; period counter 0; shift index 0.

Input synchronization:
- `TLU_BUSY` and `TLU_CLOCK` each pass through 2 flip-flops, giving `busy_s` and `clk_s`.
- A third flip-flop on `clk_s` provides rising-edge detection, `clk_rise`.

State machine:
- **IDLE**
  - If `RESET_CMD` is pending: go to RST_PULSE.
  - Otherwise, if `ENABLE` is high: load the counter with `PERIOD` and go to WAIT_PERIOD.
- **WAIT_PERIOD**
  - If `RESET_CMD` is pending: go to RST_PULSE.
  - Otherwise, if `ENABLE` is low: go to IDLE.
  - Otherwise, if the counter is 0: set `TLU_TRIGGER` to 1 and go to TRIG.
  - Otherwise: decrement the counter.
- **TRIG**, mode 00
  - Hold `TLU_TRIGGER` high for max(`PULSE_LEN`, 1) cycles.
  - Then drive it low and go to DONE.
- **TRIG**, modes 01 and 10
  - Hold `TLU_TRIGGER` high until `busy_s` is 1.
  - Then drive `TLU_TRIGGER` low. Go to WAIT_RELEASE in mode 01, or to SHIFT in mode 10.
  - Timeout: if `busy_s` has not been seen after 256 cycles in TRIG, set `TIMEOUT_ERROR`, drive `TLU_TRIGGER` low and go to DONE.
- **SHIFT**
  - On each `clk_rise`, `TLU_TRIGGER` is set to `TRIGGER_NUMBER[idx]` and `idx` increments. Bits are sent LSB first, starting at idx 0.
  - Once idx ≥ `TRIGGER_BITS`, `TLU_TRIGGER` is driven 0 on every further `clk_rise`.
  - When `busy_s` is 0: drive `TLU_TRIGGER` low, clear idx and go to DONE.
- **WAIT_RELEASE**
  - When `busy_s` is 0: go to DONE.
  - There is no timeout on a stuck busy.
- **DONE** (1 cycle)
  - Increment `TRIGGER_NUMBER`. It wraps from 0xFFFFFFFF to 0.
  - Load the counter with `PERIOD`.
  - Go to WAIT_PERIOD if `ENABLE` is high and no reset is pending; otherwise go to IDLE.
- **RST_PULSE** (4 cycles)
  - `TLU_RESET` is 1 for the 4 cycles.
  - `TRIGGER_NUMBER` is set to 0 on entry.
  - Clear the pending flag, then go to IDLE.

Boundary rules:
- A `RESET_CMD` pulse arriving during TRIG, SHIFT, WAIT_RELEASE or DONE is latched as pending. It is served after DONE (DONE → IDLE → RST_PULSE). Multiple pulses collapse into one.
- Dropping `ENABLE` mid-transaction never truncates the transaction: it completes, including the increment.
- The timeout path still increments `TRIGGER_NUMBER` in DONE.
- `ERROR_CLR` in the same cycle as a timeout set: set wins.
- Asserting `BUS_RST_N` low mid-transaction forces all outputs to 0 immediately and discards any pending reset.

## Timing

- `ENABLE` sampled high at edge n in IDLE: WAIT_PERIOD from n+1, and `TLU_TRIGGER` rises at edge n+1+`PERIOD`.
- `TLU_BUSY` rising to `TLU_TRIGGER` falling: 3 cycles (2 synchronizer cycles plus 1 registered output).
- `TLU_CLOCK` rising to a new data bit on `TLU_TRIGGER`: 3 cycles.
- `TLU_CLOCK` requirement: each half-period must be at least 3 `BUS_CLK` cycles. DIVISOR 12 gives 6, which satisfies this.
- Transaction gap: the next trigger rises `PERIOD`+2 cycles after the cycle in which `busy_s` is first seen 0 (SHIFT/WAIT_RELEASE → DONE → WAIT_PERIOD, then `PERIOD` countdown cycles → TRIG).
- `TRIGGER_NUMBER` updates on the edge leaving DONE.

## Test plan

- **Mode 00 free-run**: `PERIOD`=10, `PULSE_LEN`=3, `ENABLE`=1 for 100 cycles → 3-cycle trigger pulses starting every 15 cycles; `TRIGGER_NUMBER` counts 0,1,2,…
- **Mode 01 handshake**: the bench raises busy 5 cycles after the trigger rises and drops it 20 cycles later → trigger falls 3 cycles after busy rises; `TRIGGER_NUMBER` increments exactly once per transaction.
- **Mode 10 data**: `TRIGGER_NUMBER` preset to 0x5A3C by prior runs, `TRIGGER_BITS`=15, controller model with DIVISOR 12 → bits sampled on the controller's clock edges decode to 0x5A3C; the 16th and later bits are 0.
- **Timeout**: mode 01 with busy never asserted → `TIMEOUT_ERROR`=1 after 256 cycles of trigger high; the trigger drops; the number increments; `ERROR_CLR` clears the flag.
- **Deferred reset**: `RESET_CMD` pulsed during SHIFT → shifting completes, then `TLU_RESET` is high for 4 cycles and `TRIGGER_NUMBER`=0.
- **Wrap and async reset**: `TRIGGER_NUMBER`=0xFFFFFFFF plus one transaction → 0. `BUS_RST_N` low mid-SHIFT → all outputs 0 at once and the state returns to IDLE.
